seq_alu: RTL and testbench

Registered, width-parametrised successor to the 4-bit combinational ALU. It has the same operation set and flag semantics. It adds signed set-less-than and a multi-cycle shift-add multiplier. Operands enter through a valid/ready handshake, and results leave through a valid/ready handshake. The block sits between the operand/control source (switch/keyboard front end or a sequencer) and the result display/writeback logic.

---
 rtl/seq_alu.sv | 232 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered, width-parametrised ALU with valid/ready handshakes on
// both the operand side and the result side.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand/op presented by the source
//   in_ready   block can accept an operation this cycle
//   op[2:0]    000 add, 001 sub, 010 mul, 011 and, 100 or, 101 xor,
//              110 slt (signed), 111 eq
//   a, b       operands (WIDTH bits)
//   out_valid  result and flags valid
//   out_ready  consumer takes the result this cycle
//   result     registered result (WIDTH bits)
//   zero_f     result == 0
//   over_f     signed overflow
//   cout_f     carry out / multiply high part nonzero
//
// Build option: define SEQ_ALU_MUL_EN to build the multi-cycle shift-add
// multiplier (op 010 takes WIDTH cycles). Without it, op 010 completes in one
// cycle with result 0, zero_f 1, cout_f 0, over_f 0.

module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_f,
  output logic             over_f,
  output logic             cout_f
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SLT = 3'b110,
    OP_EQ  = 3'b111
  } op_t;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  // Overflow when both addends share a sign and the sum's sign differs;
  // for subtraction the second addend is ~b, whose sign is the inverse of b.
  assign w_add_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB]  != a[MSB]);
  assign w_sub_ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = w_add_ovf;
      end
      OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = w_sub_ovf;
      end
      OP_AND: w_alu_res = a & b;
      OP_OR:  w_alu_res = a | b;
      OP_XOR: w_alu_res = a ^ b;
      OP_SLT: begin
        w_alu_res = WIDTH'(w_diff[MSB] ^ w_sub_ovf);
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = w_sub_ovf;
      end
      OP_EQ: begin
        w_alu_res = WIDTH'(w_diff[WIDTH-1:0] == '0);
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = w_sub_ovf;
      end
      default: ;  // OP_MUL: zero result on the single-cycle path
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and registered outputs
  // ---------------------------------------------------------------------------
  logic             r_out_valid, w_out_valid_nxt;
  logic [WIDTH-1:0] r_result,    w_result_nxt;
  logic             r_zero,      w_zero_nxt;
  logic             r_over,      w_over_nxt;
  logic             r_cout,      w_cout_nxt;
  logic             w_idle;
  logic             w_accept;

`ifdef SEQ_ALU_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             r_state,  w_state_nxt;
  logic [2*WIDTH-1:0] r_mcand,  w_mcand_nxt;
  logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;
  logic [2*WIDTH-1:0] r_acc,    w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
  logic [2*WIDTH-1:0] w_acc_step;

  assign w_idle     = (r_state == S_IDLE);
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
`else
  assign w_idle = 1'b1;
`endif

  assign in_ready = w_idle && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_out_valid_nxt = r_out_valid;
    w_result_nxt    = r_result;
    w_zero_nxt      = r_zero;
    w_over_nxt      = r_over;
    w_cout_nxt      = r_cout;
`ifdef SEQ_ALU_MUL_EN
    w_state_nxt     = r_state;
    w_mcand_nxt     = r_mcand;
    w_mplier_nxt    = r_mplier;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
`endif

    // A consumed result disappears unless a new one is loaded at the same edge.
    if (out_ready) begin
      w_out_valid_nxt = 1'b0;
    end

    if (w_accept) begin
`ifdef SEQ_ALU_MUL_EN
      if (op_t'(op) == OP_MUL) begin
        w_state_nxt     = S_MUL;
        w_mcand_nxt     = {{WIDTH{1'b0}}, a};
        w_mplier_nxt    = b;
        w_acc_nxt       = '0;
        w_cnt_nxt       = '0;
        w_out_valid_nxt = 1'b0;
      end else
`endif
      begin
        w_result_nxt    = w_alu_res;
        w_zero_nxt      = (w_alu_res == '0);
        w_over_nxt      = w_alu_v;
        w_cout_nxt      = w_alu_c;
        w_out_valid_nxt = 1'b1;
      end
    end

`ifdef SEQ_ALU_MUL_EN
    if (r_state == S_MUL) begin
      w_acc_nxt    = w_acc_step;
      w_mcand_nxt  = r_mcand << 1;
      w_mplier_nxt = r_mplier >> 1;
      w_cnt_nxt    = r_cnt + CNT_W'(1);
      // The last step's sum goes straight to the outputs so the result lands
      // exactly WIDTH edges after the accepting edge.
      if (r_cnt == CNT_W'(WIDTH - 1)) begin
        w_state_nxt     = S_IDLE;
        w_result_nxt    = w_acc_step[WIDTH-1:0];
        w_zero_nxt      = (w_acc_step[WIDTH-1:0] == '0);
        w_over_nxt      = 1'b0;
        w_cout_nxt      = |w_acc_step[2*WIDTH-1:WIDTH];
        w_out_valid_nxt = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_over      <= 1'b0;
      r_cout      <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
`endif
    end else begin
      r_out_valid <= w_out_valid_nxt;
      r_result    <= w_result_nxt;
      r_zero      <= w_zero_nxt;
      r_over      <= w_over_nxt;
      r_cout      <= w_cout_nxt;
`ifdef SEQ_ALU_MUL_EN
      r_state     <= w_state_nxt;
      r_mcand     <= w_mcand_nxt;
      r_mplier    <= w_mplier_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero_f    = r_zero;
  assign over_f    = r_over;
  assign cout_f    = r_cout;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=8: directed scenarios plus a
// randomized run scored against an arithmetic reference model.

module tb_seq_alu;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero_f;
  logic         over_f;
  logic         cout_f;

  int n_checks = 0;
  int n_pass   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero_f    (zero_f),
    .over_f    (over_f),
    .cout_f    (cout_f)
  );

  always #5 clk = ~clk;

  // {out_valid, cout_f, over_f, zero_f, result}
  logic [11:0] obs;
  assign obs = {out_valid, cout_f, over_f, zero_f, result};

  // Reference model: {cout, over, zero, result} from plain integer arithmetic.
  function automatic logic [10:0] model(input logic [2:0] mop,
                                        input logic [7:0] ma,
                                        input logic [7:0] mb);
    int ua = ma;
    int ub = mb;
    int sa = $signed(ma);
    int sb = $signed(mb);
    int r = 0;
    int c = 0;
    int v = 0;
    case (mop)
      3'd0: begin r = (ua + ub) % 256; c = (ua + ub) > 255;
                  v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin r = (ua - ub + 256) % 256; c = (ua >= ub);
                  v = (sa - sb > 127) || (sa - sb < -128); end
`ifdef SEQ_ALU_MUL_EN
      3'd2: begin r = (ua * ub) % 256; c = (ua * ub) > 255; end
`else
      3'd2: r = 0;
`endif
      3'd3: r = ua & ub;
      3'd4: r = ua | ub;
      3'd5: r = ua ^ ub;
      3'd6: begin r = (sa < sb) ? 1 : 0; c = (ua >= ub);
                  v = (sa - sb > 127) || (sa - sb < -128); end
      default: begin r = (ua == ub) ? 1 : 0; c = (ua >= ub);
                  v = (sa - sb > 127) || (sa - sb < -128); end
    endcase
    return {c[0], v[0], (r == 0), r[7:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1; op = o; a = x; b = y;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if (obs !== 12'h000) $display("FAIL reset_outputs got=%h exp=%h", obs, 12'h000);
    else n_pass++;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_ready got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1;
    issue(3'd0, 8'h7F, 8'h01);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, 8'h80}) $display("FAIL add_ovf got=%h exp=%h", obs, {1'b1, 3'b010, 8'h80});
    else n_pass++;
    issue(3'd1, 8'h05, 8'h05);
    n_checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b1, 8'h00}) $display("FAIL sub_zero got=%h exp=%h", obs, {1'b1, 3'b101, 8'h00});
    else n_pass++;
  endtask

  task automatic test_slt_eq();
    out_ready = 1'b1;
    issue(3'd6, 8'hFE, 8'h01);
    n_checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h01}) $display("FAIL slt_neg_pos got=%h exp=%h", obs, {1'b1, 3'b100, 8'h01});
    else n_pass++;
    issue(3'd6, 8'h01, 8'hFE);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, 8'h00}) $display("FAIL slt_pos_neg got=%h exp=%h", obs, {1'b1, 3'b001, 8'h00});
    else n_pass++;
    issue(3'd7, 8'h3C, 8'h3C);
    n_checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h01}) $display("FAIL eq_equal got=%h exp=%h", obs, {1'b1, 3'b100, 8'h01});
    else n_pass++;
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
`ifdef SEQ_ALU_MUL_EN
    issue(3'd2, 8'h10, 8'h11);
    // Source keeps an add asserted during the multiply; it must be ignored.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; op = 3'd0; a = 8'h01; b = 8'h01;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL mul_busy cyc=%0d got valid=%b ready=%b exp 0/0", i, out_valid, in_ready);
      else n_pass++;
      if (i < 7) step();
      else begin @(posedge clk); #1; end
    end
    in_valid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h10}) $display("FAIL mul_result got=%h exp=%h", obs, {1'b1, 3'b100, 8'h10});
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL mul_no_extra got valid=%b exp 0", out_valid);
    else n_pass++;
`else
    issue(3'd2, 8'h10, 8'h11);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, 8'h00}) $display("FAIL mul_off got=%h exp=%h", obs, {1'b1, 3'b001, 8'h00});
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    out_ready = 1'b1;
    issue(3'd2, 8'hFF, 8'hFF);
    step(); step();
    rst = 1'b1;
    step();
    n_checks++;
    if (obs !== 12'h000 || in_ready !== 1'b1)
      $display("FAIL reset_mid_mul got=%h ready=%b exp=000 ready=1", obs, in_ready);
    else n_pass++;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL reset_discard got a result after reset exp none");
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    issue(3'd5, 8'hF0, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs !== {1'b1, 3'b000, 8'hFF} || in_ready !== 1'b0)
        $display("FAIL bp_hold cyc=%0d got=%h ready=%b exp=%h ready=0", i, obs, in_ready, {1'b1, 3'b000, 8'hFF});
      else n_pass++;
      step();
    end
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd3; a = 8'hCC; b = 8'hAA;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_release got ready=%b exp 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 3'b000, 8'h88}) $display("FAIL bp_no_bubble got=%h exp=%h", obs, {1'b1, 3'b000, 8'h88});
    else n_pass++;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd3; a = 8'h0F; b = 8'h3C;
    step();
    n_checks++;
    if (obs !== {1'b1, 3'b000, 8'h0C}) $display("FAIL stream_and got=%h exp=%h", obs, {1'b1, 3'b000, 8'h0C});
    else n_pass++;
    op = 3'd4; a = 8'h0F; b = 8'h30;
    step();
    n_checks++;
    if (obs !== {1'b1, 3'b000, 8'h3F}) $display("FAIL stream_or got=%h exp=%h", obs, {1'b1, 3'b000, 8'h3F});
    else n_pass++;
    op = 3'd0; a = 8'h01; b = 8'hFF;
    step();
    n_checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b1, 8'h00}) $display("FAIL stream_add got=%h exp=%h", obs, {1'b1, 3'b101, 8'h00});
    else n_pass++;
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL stream_drain got valid=%b exp 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [10:0] q[$];
    logic [10:0] exp_v;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom_range(0, 7));
      a         = 8'($urandom);
      b         = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL rand_spurious got=%h exp none", obs[10:0]);
        else begin
          exp_v = q.pop_front();
          if (obs[10:0] !== exp_v) $display("FAIL rand_result idx=%0d got=%h exp=%h", i, obs[10:0], exp_v);
          else n_pass++;
        end
      end
      if (in_valid && in_ready) q.push_back(model(op, a, b));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      #1;
      if (out_valid) begin
        n_checks++;
        exp_v = q.pop_front();
        if (obs[10:0] !== exp_v) $display("FAIL rand_drain got=%h exp=%h", obs[10:0], exp_v);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL rand_timeout got %0d pending exp 0", q.size());
    else n_pass++;
  endtask

  initial begin
    #1;
    test_reset();
    test_add_sub();
    test_slt_eq();
    test_mul();
    test_reset_mid_mul();
    test_back_to_back();
    test_stream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
